// File: rtl/i2c_transaction_sequencer.sv
// i2c_transaction_sequencer
//   Turns one CPU transaction request (7-bit address, R/W, N bytes) into a START, address TX,
//   N data TX/RX and STOP command stream for the byte-level I2C unit. Only one unit command is
//   in flight at a time. Also generates the unit's cycleDone bus-timing tick and tracks NACKs.
//
// Ports
//   clk, reset                 system clock, asynchronous active-high reset
//   clocksPerCycle             clk cycles per cycleDone tick (0 behaves as 1), latched at start
//   start, abort               transaction request pulse / early termination request
//   slaveAddr, readNotWrite    target address and direction (1 = read)
//   byteCount                  number of data bytes (0 = address-only probe)
//   wrData, wrValid, wrReady   write byte stream from upstream
//   rdData, rdValid            received byte, rdValid is a 1-clk pulse
//   busy, done, nackError      status: in progress, 1-clk completion pulse, sticky NACK
//   cycleDone                  bus-timing tick to the unit
//   command, transmitData,
//   transmitAck, transmitValid command handshake to the unit (00 START 01 STOP 10 TX 11 RX)
//   transmitReady              unit accepted the command
//   receiveData, receiveAck,
//   receiveValid, unitBusy     unit completion / status

module i2c_transaction_sequencer #(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] clocksPerCycle,
    input  logic                 start,
    input  logic                 abort,
    input  logic [6:0]           slaveAddr,
    input  logic                 readNotWrite,
    input  logic [7:0]           byteCount,
    input  logic [7:0]           wrData,
    input  logic                 wrValid,
    output logic                 wrReady,
    output logic [7:0]           rdData,
    output logic                 rdValid,
    output logic                 busy,
    output logic                 done,
    output logic                 nackError,
    output logic                 cycleDone,
    output logic [1:0]           command,
    output logic [7:0]           transmitData,
    output logic                 transmitAck,
    output logic                 transmitValid,
    input  logic                 transmitReady,
    input  logic [7:0]           receiveData,
    input  logic                 receiveAck,
    input  logic                 receiveValid,
    input  logic                 unitBusy
);

    typedef enum logic [1:0] {
        CmdStart = 2'b00,
        CmdStop  = 2'b01,
        CmdTx    = 2'b10,
        CmdRx    = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StAccept,
        StWait,
        StNext,
        StGetWr,
        StDone
    } state_e;

    state_e               state_q, state_d;
    cmd_e                 cmd_q, cmd_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_ack_q, tx_ack_d;
    logic                 is_addr_q, is_addr_d;   // in-flight TX is the address byte
    logic [6:0]           addr_q, addr_d;
    logic                 rnw_q, rnw_d;
    logic [7:0]           remain_q, remain_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] tick_q, tick_d;
    logic                 nack_q, nack_d;
    logic                 abort_q, abort_d;
    logic [7:0]           rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;

    // Command to launch this cycle (moves the FSM to StIssue)
    logic                 issue;
    cmd_e                 issue_cmd;
    logic [7:0]           issue_data;
    logic                 issue_ack;
    logic                 issue_addr;

    logic                 busy_w;
    logic [DIV_WIDTH-1:0] div_last;
    logic                 tick_w;

    assign busy_w = (state_q != StIdle) && (state_q != StDone);

    // Tick period is max(div,1); the counter sits at zero whenever the sequencer is idle.
    always_comb begin
        div_last = '0;
        if (div_q != '0) begin
            div_last = div_q - DIV_WIDTH'(1);
        end
        tick_w = busy_w && (tick_q >= div_last);
        tick_d = '0;
        if (busy_w && !tick_w) begin
            tick_d = tick_q + DIV_WIDTH'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        tx_data_d  = tx_data_q;
        tx_ack_d   = tx_ack_q;
        is_addr_d  = is_addr_q;
        addr_d     = addr_q;
        rnw_d      = rnw_q;
        remain_d   = remain_q;
        div_d      = div_q;
        nack_d     = nack_q;
        abort_d    = abort_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        issue      = 1'b0;
        issue_cmd  = CmdStop;
        issue_data = 8'h00;
        issue_ack  = 1'b1;
        issue_addr = 1'b0;

        if (busy_w && abort) begin
            abort_d = 1'b1;
        end

        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    addr_d    = slaveAddr;
                    rnw_d     = readNotWrite;
                    remain_d  = byteCount;
                    div_d     = clocksPerCycle;
                    nack_d    = 1'b0;
                    abort_d   = 1'b0;
                    issue     = 1'b1;
                    issue_cmd = CmdStart;
                end
            end

            StIssue: begin
                state_d = StAccept;
            end

            StAccept: begin
                if (transmitReady) begin
                    state_d = StWait;
                end
            end

            StWait: begin
                unique case (cmd_q)
                    CmdStart, CmdStop: begin
                        if (!unitBusy) begin
                            state_d = StNext;
                        end
                    end
                    CmdTx: begin
                        if (receiveValid) begin
                            if (receiveAck) begin
                                nack_d = 1'b1;
                            end
                            if (!is_addr_q) begin
                                remain_d = remain_q - 8'd1;
                            end
                            state_d = StNext;
                        end
                    end
                    CmdRx: begin
                        if (receiveValid) begin
                            rd_data_d  = receiveData;
                            rd_valid_d = 1'b1;
                            remain_d   = remain_q - 8'd1;
                            state_d    = StNext;
                        end
                    end
                endcase
            end

            StNext: begin
                if (cmd_q == CmdStop) begin
                    state_d = StDone;
                end else if (abort_q || nack_q || (cmd_q != CmdStart && remain_q == 8'd0)) begin
                    issue     = 1'b1;
                    issue_cmd = CmdStop;
                end else if (cmd_q == CmdStart) begin
                    issue      = 1'b1;
                    issue_cmd  = CmdTx;
                    issue_data = {addr_q, rnw_q};
                    issue_addr = 1'b1;
                end else if (rnw_q) begin
                    // NACK the final byte so the slave releases SDA before STOP
                    issue     = 1'b1;
                    issue_cmd = CmdRx;
                    issue_ack = (remain_q == 8'd1);
                end else begin
                    state_d = StGetWr;
                end
            end

            StGetWr: begin
                if (abort_q || abort) begin
                    issue     = 1'b1;
                    issue_cmd = CmdStop;
                end else if (wrValid) begin
                    issue      = 1'b1;
                    issue_cmd  = CmdTx;
                    issue_data = wrData;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        if (issue) begin
            cmd_d     = issue_cmd;
            tx_data_d = issue_data;
            tx_ack_d  = issue_ack;
            is_addr_d = issue_addr;
            state_d   = StIssue;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cmd_q      <= CmdStart;
            tx_data_q  <= 8'h00;
            tx_ack_q   <= 1'b1;
            is_addr_q  <= 1'b0;
            addr_q     <= 7'h00;
            rnw_q      <= 1'b0;
            remain_q   <= 8'h00;
            div_q      <= '0;
            tick_q     <= '0;
            nack_q     <= 1'b0;
            abort_q    <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            tx_data_q  <= tx_data_d;
            tx_ack_q   <= tx_ack_d;
            is_addr_q  <= is_addr_d;
            addr_q     <= addr_d;
            rnw_q      <= rnw_d;
            remain_q   <= remain_d;
            div_q      <= div_d;
            tick_q     <= tick_d;
            nack_q     <= nack_d;
            abort_q    <= abort_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        busy          = busy_w;
        done          = (state_q == StDone);
        nackError     = nack_q;
        cycleDone     = tick_w;
        command       = cmd_q;
        transmitData  = tx_data_q;
        transmitAck   = tx_ack_q;
        transmitValid = (state_q == StIssue) || (state_q == StAccept);
        // Withhold the handshake once an abort is seen so no further byte is consumed
        wrReady       = (state_q == StGetWr) && !abort_q && !abort;
        rdData        = rd_data_q;
        rdValid       = rd_valid_q;
    end

endmodule

// File: tb/tb_i2c_transaction_sequencer.sv
module tb_i2c_transaction_sequencer;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] clocksPerCycle;
    logic          start, abort;
    logic [6:0]    slaveAddr;
    logic          readNotWrite;
    logic [7:0]    byteCount;
    logic [7:0]    wrData;
    logic          wrValid;
    logic          wrReady;
    logic [7:0]    rdData;
    logic          rdValid, busy, done, nackError, cycleDone;
    logic [1:0]    command;
    logic [7:0]    transmitData;
    logic          transmitAck, transmitValid;
    logic          transmitReady;
    logic [7:0]    receiveData;
    logic          receiveAck, receiveValid, unitBusy;

    i2c_transaction_sequencer #(.DIV_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .clocksPerCycle(clocksPerCycle), .start(start), .abort(abort),
        .slaveAddr(slaveAddr), .readNotWrite(readNotWrite), .byteCount(byteCount),
        .wrData(wrData), .wrValid(wrValid), .wrReady(wrReady), .rdData(rdData),
        .rdValid(rdValid), .busy(busy), .done(done), .nackError(nackError),
        .cycleDone(cycleDone), .command(command), .transmitData(transmitData),
        .transmitAck(transmitAck), .transmitValid(transmitValid),
        .transmitReady(transmitReady), .receiveData(receiveData), .receiveAck(receiveAck),
        .receiveValid(receiveValid), .unitBusy(unitBusy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] cmd;
        logic [7:0] data;
        logic       ack;
    } log_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus memories shared with the unit model
    logic [7:0] wr_mem[256];
    logic [7:0] rx_mem[256];
    int         nack_tx = -1;

    // Behavioural I2C unit: accepts one command, stays busy a random time, then completes.
    log_t log_q[$];
    int   u_cnt, tx_idx, rx_idx;
    logic [1:0] u_cmd;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            unitBusy      <= 1'b0;
            transmitReady <= 1'b0;
            receiveValid  <= 1'b0;
            receiveAck    <= 1'b0;
            receiveData   <= 8'h00;
            u_cnt         <= 0;
            u_cmd         <= 2'b00;
        end else begin
            transmitReady <= 1'b0;
            receiveValid  <= 1'b0;
            if (!unitBusy) begin
                if (transmitValid) begin
                    log_q.push_back(log_t'{command, transmitData, transmitAck});
                    u_cmd         <= command;
                    unitBusy      <= 1'b1;
                    transmitReady <= 1'b1;
                    u_cnt         <= $urandom_range(1, 4);
                    if (command == 2'b00) begin
                        tx_idx <= 0;
                        rx_idx <= 0;
                    end
                end
            end else if (u_cnt == 0) begin
                unitBusy <= 1'b0;
                if (u_cmd == 2'b10) begin
                    receiveValid <= 1'b1;
                    receiveAck   <= (tx_idx == nack_tx);
                    tx_idx       <= tx_idx + 1;
                end else if (u_cmd == 2'b11) begin
                    receiveValid <= 1'b1;
                    receiveAck   <= 1'b0;
                    receiveData  <= rx_mem[rx_idx];
                    rx_idx       <= rx_idx + 1;
                end
            end else begin
                u_cnt <= u_cnt - 1;
            end
        end
    end

    // Passive monitors
    int         cyc = 0;
    int         done_total = 0;
    int         wr_hs_total = 0;
    int         wrready_total = 0;
    int         busy_rise = 0;
    logic       busy_prev = 1'b0;
    int         tick_q[$];
    logic [7:0] rd_q[$];

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        busy_prev <= busy;
        if (busy && !busy_prev) busy_rise <= cyc;
        if (busy && cycleDone) tick_q.push_back(cyc);
        if (done) done_total <= done_total + 1;
        if (wrValid && wrReady) wr_hs_total <= wr_hs_total + 1;
        if (wrReady) wrready_total <= wrready_total + 1;
        if (rdValid) rd_q.push_back(rdData);
    end

    task automatic run_txn(input string name, input logic [6:0] a, input logic rnw, input int n,
                           input int nack_at, input int abort_at, input logic [DW-1:0] div,
                           input bit poke_start);
        log_t       exp_q[$];
        logic [7:0] exp_rd[$];
        int         exp_wr;
        bit         exp_nack, stop_now, aborted;
        int         lb, db, wb, rb, rdyb, cycles, idx;
        log_t       got;

        // Reference: command list derived from the transaction description
        exp_q.push_back(log_t'{2'b00, 8'h00, 1'b1});
        exp_q.push_back(log_t'{2'b10, {a, rnw}, 1'b1});
        exp_wr   = 0;
        exp_nack = (nack_at == 0);
        stop_now = (nack_at == 0) || (abort_at == 0);
        for (int i = 0; i < n && !stop_now; i++) begin
            if (rnw) begin
                exp_q.push_back(log_t'{2'b11, 8'h00, (i == n - 1)});
                exp_rd.push_back(rx_mem[i]);
            end else begin
                exp_q.push_back(log_t'{2'b10, wr_mem[i], 1'b1});
                exp_wr++;
                if (nack_at == i + 1) begin
                    exp_nack = 1'b1;
                    stop_now = 1'b1;
                end
            end
            if (abort_at == i + 1) stop_now = 1'b1;
        end
        exp_q.push_back(log_t'{2'b01, 8'h00, 1'b1});

        nack_tx = nack_at;
        lb = log_q.size(); db = done_total; wb = wr_hs_total; rb = rd_q.size();
        rdyb = wrready_total;
        aborted = 1'b0;

        @(negedge clk);
        slaveAddr = a; readNotWrite = rnw; byteCount = n[7:0]; clocksPerCycle = div;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clocksPerCycle = DW'($urandom_range(0, 9));   // must not affect the latched divider
        cycles = 0;
        while (done_total == db && cycles < 4000) begin
            idx     = wr_hs_total - wb;
            wrValid = !rnw && (idx < n) && ($urandom_range(0, 3) != 0);
            wrData  = (idx < n && idx < 256) ? wr_mem[idx] : 8'h00;
            abort   = 1'b0;
            start   = 1'b0;
            if (abort_at >= 0 && !aborted && (log_q.size() - lb) >= abort_at + 2) begin
                abort   = 1'b1;
                aborted = 1'b1;
            end
            if (poke_start && cycles == 8) begin
                start     = 1'b1;
                slaveAddr = ~a;
            end
            @(negedge clk);
            cycles++;
        end
        wrValid = 1'b0; abort = 1'b0; start = 1'b0;
        n_checks++;
        if (cycles >= 4000) begin
            n_fail++;
            $display("FAIL %s timeout: no done within %0d cycles", name, cycles);
        end
        repeat (6) @(negedge clk);

        n_checks++;
        if (log_q.size() - lb != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s cmd_count: got %0d expected %0d", name, log_q.size() - lb,
                     exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && lb + i < log_q.size(); i++) begin
            got = log_q[lb + i];
            n_checks++;
            if (got.cmd !== exp_q[i].cmd ||
                (exp_q[i].cmd == 2'b10 && got.data !== exp_q[i].data) ||
                (exp_q[i].cmd == 2'b11 && got.ack !== exp_q[i].ack)) begin
                n_fail++;
                $display("FAIL %s cmd[%0d]: got cmd=%b data=%h ack=%b expected cmd=%b data=%h ack=%b",
                         name, i, got.cmd, got.data, got.ack, exp_q[i].cmd, exp_q[i].data,
                         exp_q[i].ack);
            end
        end
        n_checks++;
        if (wr_hs_total - wb != exp_wr) begin
            n_fail++;
            $display("FAIL %s wr_handshakes: got %0d expected %0d", name, wr_hs_total - wb, exp_wr);
        end
        if (exp_wr == 0 && !rnw) begin
            n_checks++;
            if (wrready_total != rdyb) begin
                n_fail++;
                $display("FAIL %s wrReady_cycles: got %0d expected 0", name, wrready_total - rdyb);
            end
        end
        n_checks++;
        if (rd_q.size() - rb != exp_rd.size()) begin
            n_fail++;
            $display("FAIL %s rd_count: got %0d expected %0d", name, rd_q.size() - rb, exp_rd.size());
        end
        for (int i = 0; i < exp_rd.size() && rb + i < rd_q.size(); i++) begin
            n_checks++;
            if (rd_q[rb + i] !== exp_rd[i]) begin
                n_fail++;
                $display("FAIL %s rd[%0d]: got %h expected %h", name, i, rd_q[rb + i], exp_rd[i]);
            end
        end
        n_checks++;
        if (done_total - db != 1) begin
            n_fail++;
            $display("FAIL %s done_pulses: got %0d expected 1", name, done_total - db);
        end
        n_checks++;
        if (nackError !== exp_nack) begin
            n_fail++;
            $display("FAIL %s nackError: got %b expected %b", name, nackError, exp_nack);
        end
        n_checks++;
        if (busy !== 1'b0 || transmitValid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_after_done: got busy=%b tv=%b expected 0 0", name, busy,
                     transmitValid);
        end
    endtask

    task automatic test_reset();
        logic [24:0] got;
        reset = 1'b1; start = 1'b0; abort = 1'b0; wrValid = 1'b0; wrData = 8'h00;
        slaveAddr = 7'h00; readNotWrite = 1'b0; byteCount = 8'h00; clocksPerCycle = '0;
        repeat (3) @(negedge clk);
        got = {wrReady, rdData, rdValid, busy, done, nackError, cycleDone, command, transmitData,
               transmitValid};
        n_checks++;
        if (got !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", got);
        end
        n_checks++;
        if (transmitAck !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_transmitAck: got %b expected 1", transmitAck);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_tick(input logic [DW-1:0] div);
        int tb0, per, bad;
        per = (div == '0) ? 1 : int'(div);
        tb0 = tick_q.size();
        run_txn("tick_probe", 7'($urandom), 1'b0, 0, -1, -1, div, 1'b0);
        n_checks++;
        if (tick_q.size() - tb0 < 2) begin
            n_fail++;
            $display("FAIL tick_count div=%0d: got %0d expected >=2", div, tick_q.size() - tb0);
        end else begin
            n_checks++;
            if (tick_q[tb0] - busy_rise != per - 1) begin
                n_fail++;
                $display("FAIL tick_first div=%0d: got offset %0d expected %0d", div,
                         tick_q[tb0] - busy_rise, per - 1);
            end
            bad = -1;
            for (int i = tb0 + 1; i < tick_q.size(); i++) begin
                if (bad < 0 && tick_q[i] - tick_q[i - 1] != per) bad = i;
            end
            n_checks++;
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL tick_period div=%0d: got %0d expected %0d", div,
                         tick_q[bad] - tick_q[bad - 1], per);
            end
        end
    endtask

    task automatic test_write_basic();
        wr_mem[0] = 8'hA5; wr_mem[1] = 8'h3C;
        run_txn("write_2", 7'h50, 1'b0, 2, -1, -1, 16'd2, 1'b0);
    endtask

    task automatic test_read_basic();
        rx_mem[0] = 8'h11; rx_mem[1] = 8'h22; rx_mem[2] = 8'h33;
        run_txn("read_3", 7'h51, 1'b1, 3, -1, -1, 16'd1, 1'b0);
    endtask

    task automatic test_addr_nack();
        wr_mem[0] = 8'h12; wr_mem[1] = 8'h34;
        run_txn("addr_nack", 7'h50, 1'b0, 2, 0, -1, 16'd3, 1'b0);
    endtask

    task automatic test_abort_write();
        for (int i = 0; i < 4; i++) wr_mem[i] = 8'($urandom);
        run_txn("abort_write", 7'h2A, 1'b0, 4, -1, 2, 16'd2, 1'b1);
    endtask

    task automatic test_reset_mid_rx();
        int lb, db, cycles;
        for (int i = 0; i < 3; i++) rx_mem[i] = 8'($urandom);
        nack_tx = -1;
        lb = log_q.size();
        @(negedge clk);
        slaveAddr = 7'h33; readNotWrite = 1'b1; byteCount = 8'd3; clocksPerCycle = 16'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        while (!((log_q.size() - lb >= 3) && unitBusy) && cycles < 2000) begin
            @(negedge clk);
            cycles++;
        end
        n_checks++;
        if (cycles >= 2000 || log_q[lb + 2].cmd !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_rx_reach: got cycles=%0d expected RX in flight", cycles);
        end
        db = done_total;
        reset = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || transmitValid !== 1'b0 || transmitAck !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_rx: got busy=%b tv=%b tack=%b expected 0 0 1", busy,
                     transmitValid, transmitAck);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (done_total != db || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_done: got done=%0d busy=%b expected 0 0", done_total - db, busy);
        end
        for (int i = 0; i < 2; i++) rx_mem[i] = 8'($urandom);
        run_txn("after_reset", 7'h44, 1'b1, 2, -1, -1, 16'd1, 1'b0);
    endtask

    task automatic test_random();
        logic       rnw;
        int         n, nack_at, abort_at;
        for (int t = 0; t < 8; t++) begin
            rnw = 1'($urandom);
            n   = $urandom_range(0, 4);
            for (int i = 0; i < n; i++) begin
                wr_mem[i] = 8'($urandom);
                rx_mem[i] = 8'($urandom);
            end
            nack_at  = (!rnw && $urandom_range(0, 2) == 0) ? $urandom_range(0, n) : -1;
            abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n + 1) : -1;
            run_txn("random", 7'($urandom), rnw, n, nack_at, abort_at,
                    DW'($urandom_range(0, 4)), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_tick(16'd3);
        test_tick(16'd0);
        test_write_basic();
        test_read_basic();
        test_addr_nack();
        test_abort_write();
        test_reset_mid_rx();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
